// File: rtl/uart_tx_pkt_arbiter.sv
// Round-robin packet framer: grants one requester, writes HDR, {ch,L}, payload, XOR CSUM into the TX FIFO.
// Latency: grant 1 cycle after req; header 1 cycle after grant; payload every 2nd cycle; done 1 cycle after CSUM.
// Backpressure: fifo_almost_full stalls HDR/LEN/CSUM writes and payload fetches; a fetched byte is always written.
//
// Ports:
//   clk_in, rst                  - clock, synchronous active-high reset
//   req / grant / done / byte_rd - per-channel request, one-hot grant, completion pulse, byte fetch strobe
//   len_flat / data_flat         - per-channel length code (L+1 bytes) and payload byte
//   fifo_din / fifo_wr_en        - FIFO write port; fifo_almost_full / fifo_full - FIFO status
//   busy                         - FSM is not idle; wr_overflow - sticky write-while-full error
module uart_tx_pkt_arbiter #(
   parameter int          NREQ     = 4,
   parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [4*NREQ-1:0]    len_flat,
   input  logic [8*NREQ-1:0]    data_flat,
   output logic [NREQ-1:0]      byte_rd,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [7:0]           fifo_din,
   output logic                 fifo_wr_en,
   input  logic                 fifo_almost_full,
   input  logic                 fifo_full,
   output logic                 wr_overflow
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_RD, S_WR, S_CSUM, S_DONE} state_t;

   state_t           state_q, state_n;
   logic [IW-1:0]    g_q, g_n;
   logic [IW-1:0]    last_q, last_n;
   logic [3:0]       len_q, len_n;
   logic [3:0]       cnt_q, cnt_n;
   logic [7:0]       csum_q, csum_n;
   logic [NREQ-1:0]  byte_rd_n, grant_n, done_n;
   logic             busy_n, wr_en_n, overflow_n;
   logic [7:0]       din_n;

   logic [7:0]       data_arr [NREQ];
   logic [3:0]       len_arr  [NREQ];

   logic             rr_found;
   logic [IW-1:0]    rr_sel, rr_idx;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = data_flat[8*i +: 8];
         len_arr[i]  = len_flat[4*i +: 4];
      end
   end

   // Search starts just after the last served channel, so the most recent winner has lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = last_q;
      rr_idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         rr_idx = IW'((int'(last_q) + i) % NREQ);
         if (!rr_found && req[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   always_comb begin
      state_n    = state_q;
      g_n        = g_q;
      last_n     = last_q;
      len_n      = len_q;
      cnt_n      = cnt_q;
      csum_n     = csum_q;
      grant_n    = grant;
      byte_rd_n  = '0;
      done_n     = '0;
      wr_en_n    = 1'b0;
      din_n      = fifo_din;
      overflow_n = wr_overflow | (fifo_wr_en & fifo_full);

      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               g_n             = rr_sel;
               len_n           = len_arr[rr_sel];
               cnt_n           = 4'd0;
               csum_n          = 8'h00;
               grant_n         = '0;
               grant_n[rr_sel] = 1'b1;
               state_n         = S_HDR;
            end
         end
         S_HDR: begin
            if (!fifo_almost_full) begin
               wr_en_n = 1'b1;
               din_n   = HDR_BYTE;
               state_n = S_LEN;
            end
         end
         S_LEN: begin
            if (!fifo_almost_full) begin
               wr_en_n = 1'b1;
               din_n   = {4'(g_q), len_q};
               csum_n  = {4'(g_q), len_q};
               state_n = S_RD;
            end
         end
         S_RD: begin
            // The almost-full check here reserves the slot used by the following WR.
            if (!fifo_almost_full) begin
               byte_rd_n[g_q] = 1'b1;
               state_n        = S_WR;
            end
         end
         S_WR: begin
            wr_en_n = 1'b1;
            din_n   = data_arr[g_q];
            csum_n  = csum_q ^ data_arr[g_q];
            if (cnt_q == len_q) begin
               state_n = S_CSUM;
            end else begin
               cnt_n   = cnt_q + 4'd1;
               state_n = S_RD;
            end
         end
         S_CSUM: begin
            if (!fifo_almost_full) begin
               wr_en_n = 1'b1;
               din_n   = csum_q;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            done_n[g_q] = 1'b1;
            grant_n     = '0;
            last_n      = g_q;
            state_n     = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= S_IDLE;
         g_q         <= '0;
         last_q      <= IW'(NREQ - 1);
         len_q       <= 4'd0;
         cnt_q       <= 4'd0;
         csum_q      <= 8'h00;
         byte_rd     <= '0;
         grant       <= '0;
         done        <= '0;
         busy        <= 1'b0;
         fifo_din    <= 8'h00;
         fifo_wr_en  <= 1'b0;
         wr_overflow <= 1'b0;
      end else begin
         state_q     <= state_n;
         g_q         <= g_n;
         last_q      <= last_n;
         len_q       <= len_n;
         cnt_q       <= cnt_n;
         csum_q      <= csum_n;
         byte_rd     <= byte_rd_n;
         grant       <= grant_n;
         done        <= done_n;
         busy        <= busy_n;
         fifo_din    <= din_n;
         fifo_wr_en  <= wr_en_n;
         wr_overflow <= overflow_n;
      end
   end

endmodule
